// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage pipeline control logic:
//   - REG_W        : register address width
//   - OP_HALT      : HALT opcode value decoded in ID (drives halt_id upstream)
//   - pipe_state_e : control FSM state encoding
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  // Primary opcode field of the HALT instruction.
  localparam logic [5:0] OP_HALT = 6'h3f;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } pipe_state_e;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detector.
// Ports:
//   rs_id, rt_id         in  source registers of the ID instruction
//   uses_rs_id/uses_rt_id in which sources the ID instruction really reads
//   outReg_exe           in  destination register of the EXE instruction
//   memRead_exe          in  EXE instruction is a load
//   wb_exe               in  EXE instruction writes the register file
//   nop_exe              in  EXE stage currently holds a bubble
//   stall                out ID must wait one cycle for the load data
// ---------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_W
) (
  input  logic [ADDR_W-1:0] rs_id,
  input  logic [ADDR_W-1:0] rt_id,
  input  logic              uses_rs_id,
  input  logic              uses_rt_id,
  input  logic [ADDR_W-1:0] outReg_exe,
  input  logic              memRead_exe,
  input  logic              wb_exe,
  input  logic              nop_exe,
  output logic              stall
);

  logic load_in_exe;
  logic dest_nonzero;
  logic rs_match;
  logic rt_match;

  always_comb begin
    // A bubble in EXE may still carry stale control bits; it never hazards.
    load_in_exe  = memRead_exe & wb_exe & ~nop_exe;
    // $0 is hard-wired to zero, so writing it creates no dependency.
    dest_nonzero = (outReg_exe != '0);
    rs_match     = uses_rs_id & (rs_id == outReg_exe);
    rt_match     = uses_rt_id & (rt_id == outReg_exe);
    stall        = load_in_exe & dest_nonzero & (rs_match | rt_match);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline control for the 5-stage MIPS core: stall / bubble / flush
// controls, per-stage nop flags for the forwarding unit, HALT drain and
// debug single-step gating.
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   rs_id, rt_id, uses_rs_id,
//   uses_rt_id                  ID instruction sources
//   outReg_exe, memRead_exe,
//   wb_exe                      EXE instruction destination / type
//   branch_taken_id             branch resolved taken in ID
//   halt_id                     HALT opcode in ID
//   step_en, step_pulse         debug single-step controls
//   pipe_en                     global enable of all pipeline registers
//   pc_write, ifid_write        PC and IF/ID load enables
//   flush_if                    load IF/ID with a nop
//   bubble_exe                  inject a nop into ID/EX
//   nop_exe, nop_mem, nop_wb    stage holds a bubble
//   halted                      pipeline fully drained after HALT
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = REG_W,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_id,
  input  logic [ADDR_W-1:0] rt_id,
  input  logic              uses_rs_id,
  input  logic              uses_rt_id,
  input  logic [ADDR_W-1:0] outReg_exe,
  input  logic              memRead_exe,
  input  logic              wb_exe,
  input  logic              branch_taken_id,
  input  logic              halt_id,
  input  logic              step_en,
  input  logic              step_pulse,
  output logic              pipe_en,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              flush_if,
  output logic              bubble_exe,
  output logic              nop_exe,
  output logic              nop_mem,
  output logic              nop_wb,
  output logic              halted
);

  // DRAIN_CYCLES is 3..7, so a 3-bit counter always suffices.
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  pipe_state_e state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic        nop_exe_q, nop_exe_d;
  logic        nop_mem_q, nop_mem_d;
  logic        nop_wb_q, nop_wb_d;

  logic        advance;
  logic        stall;

  hazard_detect #(
    .ADDR_W (ADDR_W)
  ) u_hazard_detect (
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .uses_rs_id  (uses_rs_id),
    .uses_rt_id  (uses_rt_id),
    .outReg_exe  (outReg_exe),
    .memRead_exe (memRead_exe),
    .wb_exe      (wb_exe),
    .nop_exe     (nop_exe_q),
    .stall       (stall)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      nop_exe_q   <= 1'b1;
      nop_mem_q   <= 1'b1;
      nop_wb_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      nop_exe_q   <= nop_exe_d;
      nop_mem_q   <= nop_mem_d;
      nop_wb_q    <= nop_wb_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: FSM, drain counter and nop chain
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      ST_RUN: begin
        // A stalled HALT is retried next cycle, so only an unstalled one
        // starts the drain.
        if (advance && !stall && halt_id) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (advance) begin
          if (drain_cnt_q == 3'd1) begin
            state_d     = ST_HALTED;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q - 3'd1;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = '0;
      end
    endcase

    // The nop flags travel with the pipeline registers, so they move only
    // when the whole pipeline advances.
    if (advance) begin
      nop_exe_d = bubble_exe;
      nop_mem_d = nop_exe_q;
      nop_wb_d  = nop_mem_q;
    end else begin
      nop_exe_d = nop_exe_q;
      nop_mem_d = nop_mem_q;
      nop_wb_d  = nop_wb_q;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    halted     = (state_q == ST_HALTED);
    advance    = ~halted & (~step_en | step_pulse);
    pipe_en    = advance;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    flush_if   = 1'b0;
    bubble_exe = 1'b1;

    case (state_q)
      ST_RUN: begin
        // The HALT itself must not let the PC move past it.
        pc_write   = advance & ~stall & ~halt_id;
        ifid_write = advance & ~stall;
        flush_if   = advance & ~stall & branch_taken_id;
        bubble_exe = stall | halt_id;
      end
      ST_DRAIN: begin
        bubble_exe = 1'b1;
      end
      ST_HALTED: begin
        bubble_exe = 1'b1;
      end
      default: begin
        bubble_exe = 1'b1;
      end
    endcase
  end

  assign nop_exe = nop_exe_q;
  assign nop_mem = nop_mem_q;
  assign nop_wb  = nop_wb_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed stimulus with a cycle-level behavioural model of the pipeline
// controller plus hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int DRAIN = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_id, rt_id, outReg_exe;
  logic       uses_rs_id, uses_rt_id, memRead_exe, wb_exe;
  logic       branch_taken_id, halt_id, step_en, step_pulse;
  logic       pipe_en, pc_write, ifid_write, flush_if, bubble_exe;
  logic       nop_exe, nop_mem, nop_wb, halted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .ADDR_W       (5),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .uses_rs_id      (uses_rs_id),
    .uses_rt_id      (uses_rt_id),
    .outReg_exe      (outReg_exe),
    .memRead_exe     (memRead_exe),
    .wb_exe          (wb_exe),
    .branch_taken_id (branch_taken_id),
    .halt_id         (halt_id),
    .step_en         (step_en),
    .step_pulse      (step_pulse),
    .pipe_en         (pipe_en),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .flush_if        (flush_if),
    .bubble_exe      (bubble_exe),
    .nop_exe         (nop_exe),
    .nop_mem         (nop_mem),
    .nop_wb          (nop_wb),
    .halted          (halted)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: a three-entry list of bubble flags for EXE/MEM/WB,
  // a remaining-drain-cycles count and a halted flag.
  // -------------------------------------------------------------------------
  bit m_valid  = 1'b0;
  bit m_halted = 1'b0;
  int m_left   = 0;
  bit m_pipe [3] = '{1'b1, 1'b1, 1'b1};
  bit e_adv, e_haz, e_pc, e_ifid, e_flush, e_bub;

  always @(negedge clk) begin
    #3;
    e_adv = !m_halted && (!step_en || step_pulse);
    e_haz = memRead_exe && wb_exe && !m_pipe[0] && (outReg_exe != 0) &&
            ((uses_rs_id && rs_id == outReg_exe) ||
             (uses_rt_id && rt_id == outReg_exe));
    if (m_halted || m_left > 0) begin
      e_pc = 0; e_ifid = 0; e_flush = 0; e_bub = 1;
    end else begin
      e_pc    = e_adv && !e_haz && !halt_id;
      e_ifid  = e_adv && !e_haz;
      e_flush = e_adv && !e_haz && branch_taken_id;
      e_bub   = e_haz || halt_id;
    end

    if (m_valid) begin
      chk("pipe_en", pipe_en, e_adv);
      chk("pc_write", pc_write, e_pc);
      chk("ifid_write", ifid_write, e_ifid);
      chk("flush_if", flush_if, e_flush);
      if (!m_halted) chk("bubble_exe", bubble_exe, e_bub);
      chk("nop_exe", nop_exe, m_pipe[0]);
      chk("nop_mem", nop_mem, m_pipe[1]);
      chk("nop_wb", nop_wb, m_pipe[2]);
      chk("halted", halted, m_halted);
    end

    if (reset) begin
      m_valid  = 1;
      m_halted = 0;
      m_left   = 0;
      m_pipe   = '{1'b1, 1'b1, 1'b1};
    end else if (m_valid && e_adv) begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = e_bub;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_halted = 1;
      end else if (halt_id && !e_haz) begin
        m_left = DRAIN;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus: each cycle, inputs change 1 time unit after the falling edge,
  // literal checks happen 1 unit later, the model compare 1 unit after that.
  // -------------------------------------------------------------------------
  task automatic next_cycle();
    @(negedge clk);
    #1;
    reset = 0; rs_id = 0; rt_id = 0; uses_rs_id = 0; uses_rt_id = 0;
    outReg_exe = 0; memRead_exe = 0; wb_exe = 0;
    branch_taken_id = 0; halt_id = 0; step_en = 0; step_pulse = 0;
  endtask

  task automatic load_use(input logic [4:0] dst, input logic [4:0] rs,
                          input logic urs, input logic [4:0] rt, input logic urt);
    memRead_exe = 1; wb_exe = 1; outReg_exe = dst;
    rs_id = rs; uses_rs_id = urs; rt_id = rt; uses_rt_id = urt;
  endtask

  initial begin
    reset = 1; rs_id = 0; rt_id = 0; uses_rs_id = 0; uses_rt_id = 0;
    outReg_exe = 0; memRead_exe = 0; wb_exe = 0;
    branch_taken_id = 0; halt_id = 0; step_en = 0; step_pulse = 0;

    $display("phase: reset");
    next_cycle(); reset = 1;
    next_cycle(); reset = 1;
    next_cycle(); #1;
    chk("rst_nop_exe", nop_exe, 1'b1);
    chk("rst_nop_mem", nop_mem, 1'b1);
    chk("rst_nop_wb", nop_wb, 1'b1);
    chk("rst_halted", halted, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle(); #1;
    chk("idle_nop_exe", nop_exe, 1'b0);
    chk("idle_nop_mem", nop_mem, 1'b0);
    chk("idle_nop_wb", nop_wb, 1'b0);

    $display("phase: load-use");
    next_cycle(); load_use(5'd4, 5'd4, 1, 5'd0, 0); #1;
    chk("lu_pc_write", pc_write, 1'b0);
    chk("lu_bubble", bubble_exe, 1'b1);
    next_cycle(); load_use(5'd4, 5'd4, 1, 5'd0, 0); #1;
    chk("lu_n1_nop_exe", nop_exe, 1'b1);
    chk("lu_n1_pc_write", pc_write, 1'b1);
    chk("lu_n1_bubble", bubble_exe, 1'b0);
    next_cycle();

    $display("phase: no-hazard cases");
    next_cycle(); load_use(5'd0, 5'd0, 1, 5'd0, 1); #1;
    chk("r0_pc_write", pc_write, 1'b1);
    chk("r0_bubble", bubble_exe, 1'b0);
    next_cycle(); load_use(5'd4, 5'd4, 0, 5'd5, 1); #1;
    chk("nors_pc_write", pc_write, 1'b1);
    next_cycle(); load_use(5'd9, 5'd3, 1, 5'd9, 1); #1;
    chk("rt_stall_pc", pc_write, 1'b0);
    next_cycle();

    $display("phase: branch");
    next_cycle(); branch_taken_id = 1; #1;
    chk("br_flush", flush_if, 1'b1);
    chk("br_pc_write", pc_write, 1'b1);
    next_cycle(); #1;
    chk("br_after_flush", flush_if, 1'b0);
    next_cycle(); branch_taken_id = 1; load_use(5'd7, 5'd0, 0, 5'd7, 1); #1;
    chk("brst_flush", flush_if, 1'b0);
    next_cycle(); branch_taken_id = 1; load_use(5'd7, 5'd0, 0, 5'd7, 1); #1;
    chk("brst_n1_flush", flush_if, 1'b1);
    next_cycle();

    $display("phase: single-step");
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      step_en    = 1;
      step_pulse = (i % 4 == 3);
      if (i == 3) load_use(5'd6, 5'd6, 1, 5'd0, 0);
      if (i == 5) branch_taken_id = 1;
      #1;
      if (i == 1) begin
        chk("step_hold_pc", pc_write, 1'b0);
        chk("step_hold_en", pipe_en, 1'b0);
      end
    end
    next_cycle();
    next_cycle();
    next_cycle();

    $display("phase: halt drain");
    next_cycle(); halt_id = 1; #1;
    chk("halt_pc_write", pc_write, 1'b0);
    chk("halt_bubble", bubble_exe, 1'b1);
    next_cycle();
    next_cycle();
    next_cycle(); #1;
    chk("drain3_halted", halted, 1'b0);
    next_cycle(); #1;
    chk("halted_set", halted, 1'b1);
    chk("halted_nop_wb", nop_wb, 1'b1);
    chk("halted_pipe_en", pipe_en, 1'b0);
    next_cycle(); branch_taken_id = 1;
    next_cycle(); #1;
    chk("halted_stays", halted, 1'b1);

    $display("phase: reset during drain");
    next_cycle(); reset = 1;
    next_cycle();
    next_cycle(); halt_id = 1;
    next_cycle();
    next_cycle(); reset = 1;
    next_cycle(); #1;
    chk("rd_halted", halted, 1'b0);
    chk("rd_nop_exe", nop_exe, 1'b1);
    chk("rd_nop_wb", nop_wb, 1'b1);
    chk("rd_pc_write", pc_write, 1'b1);
    next_cycle();
    next_cycle();

    #5;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
